// File: rtl/commit_trace_buffer_if.sv
// Commit-to-trace bundle: grouped retire lanes in, serialised trace records out.
// Latency: none (wires only).
// Backpressure: in_ready gates the commit side, out_ready gates the trace side.
interface commit_trace_buffer_if #(
  parameter int LANES  = 4,
  parameter int AREG_W = 8,
  parameter int PREG_W = 8,
  parameter int XLEN   = 32,
  parameter int CNT_W  = 64
);
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  // Commit side: one group of up to LANES retired instructions per cycle.
  logic [LANES-1:0]        in_valid;
  logic [LANES-1:0]        in_rat_we;
  logic [LANES*AREG_W-1:0] in_rat_addr;
  logic [LANES*PREG_W-1:0] in_rat_data;
  logic [LANES*XLEN-1:0]   in_wdata;
  logic [LANES*XLEN-1:0]   in_pc;
  logic                    in_ready;

  // Trace side: one record per accepted handshake.
  logic                    out_valid;
  logic                    out_ready;
  logic [LW-1:0]           out_lane;
  logic                    out_last;
  logic                    out_rat_we;
  logic [AREG_W-1:0]       out_rat_addr;
  logic [PREG_W-1:0]       out_rat_data;
  logic [XLEN-1:0]         out_wdata;
  logic [XLEN-1:0]         out_pc;

  // Status.
  logic                    overflow;
  logic [15:0]             drop_cnt;
  logic [CNT_W-1:0]        retire_cnt;
  logic                    empty;

  // Buffer view.
  modport slave (
    input  in_valid, in_rat_we, in_rat_addr, in_rat_data, in_wdata, in_pc, out_ready,
    output in_ready, out_valid, out_lane, out_last, out_rat_we, out_rat_addr,
           out_rat_data, out_wdata, out_pc, overflow, drop_cnt, retire_cnt, empty
  );

  // Producer/consumer view.
  modport master (
    output in_valid, in_rat_we, in_rat_addr, in_rat_data, in_wdata, in_pc, out_ready,
    input  in_ready, out_valid, out_lane, out_last, out_rat_we, out_rat_addr,
           out_rat_data, out_wdata, out_pc, overflow, drop_cnt, retire_cnt, empty
  );
endinterface

// File: rtl/commit_trace_buffer.sv
// Buffers retired commit groups and serialises them into one trace record per cycle.
// Latency: first record valid one cycle after a push into an empty buffer; groups stream back-to-back.
// Backpressure: in_ready = !full (registered, rises the cycle after a pop); groups arriving while full are dropped and counted.
module commit_trace_buffer #(
  parameter int LANES  = 4,
  parameter int AREG_W = 8,
  parameter int PREG_W = 8,
  parameter int XLEN   = 32,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  commit_trace_buffer_if.slave bus
);
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [PW-1:0]    PTR_ONE  = PW'(1);
  localparam logic [LANES-1:0] REM_ONE  = LANES'(1);
  localparam logic [CNT_W-1:0] RET_ONE  = CNT_W'(1);
  localparam logic [15:0]      DROP_MAX = 16'hFFFF;

  typedef enum logic {ST_EMPTY, ST_EMIT} state_t;

  // Group storage; the valid mask travels with the lane fields.
  logic [LANES-1:0]  mask_mem_q [DEPTH];
  logic [LANES-1:0]  we_mem_q   [DEPTH];
  logic [AREG_W-1:0] addr_mem_q [DEPTH][LANES];
  logic [PREG_W-1:0] tag_mem_q  [DEPTH][LANES];
  logic [XLEN-1:0]   wd_mem_q   [DEPTH][LANES];
  logic [XLEN-1:0]   pc_mem_q   [DEPTH][LANES];

  state_t           state_q;
  logic [LANES-1:0] rem_q;
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q, rd_nxt;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q;
  logic             overflow_q;
  logic [15:0]      drop_cnt_q;
  logic [CNT_W-1:0] retire_cnt_q;

  logic             any_valid, push, drop, emit, fire, last, pop;
  logic [LW-1:0]    sel;
  logic [LANES-1:0] sel_oh, rem_m1;

  // Lane select: lowest pending lane of the head group, and whether it is the final one.
  always_comb begin
    sel = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (rem_q[i]) sel = LW'(i);
    end
    sel_oh      = '0;
    sel_oh[sel] = 1'b1;
    rem_m1      = rem_q - REM_ONE;
    last        = (rem_q != '0) && ((rem_q & rem_m1) == '0);
  end

  // Handshake qualifiers and next occupancy.
  always_comb begin
    any_valid = |bus.in_valid;
    push      = any_valid & ~full_q;
    drop      = any_valid & full_q;
    emit      = (state_q == ST_EMIT);
    fire      = emit & bus.out_ready;
    pop       = fire & last;
    rd_nxt    = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Group write; storage itself needs no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mask_mem_q[wr_ptr_q] <= bus.in_valid;
      we_mem_q[wr_ptr_q]   <= bus.in_rat_we;
      for (int l = 0; l < LANES; l++) begin
        addr_mem_q[wr_ptr_q][l] <= bus.in_rat_addr[l*AREG_W +: AREG_W];
        tag_mem_q[wr_ptr_q][l]  <= bus.in_rat_data[l*PREG_W +: PREG_W];
        wd_mem_q[wr_ptr_q][l]   <= bus.in_wdata[l*XLEN +: XLEN];
        pc_mem_q[wr_ptr_q][l]   <= bus.in_pc[l*XLEN +: XLEN];
      end
    end
  end

  // Pointers, occupancy, registered full flag and the status counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      overflow_q   <= 1'b0;
      drop_cnt_q   <= '0;
      retire_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_nxt;
      count_q <= count_d;
      full_q  <= (count_d == FULL_CNT);
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != DROP_MAX) drop_cnt_q <= drop_cnt_q + 16'd1;
      end
      if (fire) retire_cnt_q <= retire_cnt_q + RET_ONE;
    end
  end

  // Output FSM: on the last record of a group, reload the next head's mask in
  // the same cycle so consecutive groups stream without a bubble. When only
  // the departing group is stored, the next head is whatever is being pushed now.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
      rem_q   <= '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            state_q <= ST_EMIT;
            rem_q   <= bus.in_valid;
          end
        end
        ST_EMIT: begin
          if (fire) begin
            if (!last) begin
              rem_q <= rem_q & ~sel_oh;
            end else if (count_q > CNT_ONE) begin
              rem_q <= mask_mem_q[rd_nxt];
            end else if (push) begin
              rem_q <= bus.in_valid;
            end else begin
              state_q <= ST_EMPTY;
              rem_q   <= '0;
            end
          end
        end
        default: begin
          state_q <= ST_EMPTY;
          rem_q   <= '0;
        end
      endcase
    end
  end

  // Record fields are forced to zero outside EMIT so reset and idle look clean.
  assign bus.in_ready     = ~full_q;
  assign bus.out_valid    = emit;
  assign bus.out_last     = emit & last;
  assign bus.out_lane     = emit ? sel : '0;
  assign bus.out_rat_we   = emit & we_mem_q[rd_ptr_q][sel];
  assign bus.out_rat_addr = emit ? addr_mem_q[rd_ptr_q][sel] : '0;
  assign bus.out_rat_data = emit ? tag_mem_q[rd_ptr_q][sel]  : '0;
  assign bus.out_wdata    = emit ? wd_mem_q[rd_ptr_q][sel]   : '0;
  assign bus.out_pc       = emit ? pc_mem_q[rd_ptr_q][sel]   : '0;
  assign bus.overflow     = overflow_q;
  assign bus.drop_cnt     = drop_cnt_q;
  assign bus.retire_cnt   = retire_cnt_q;
  assign bus.empty        = (count_q == '0) & ~emit;

  // Structural invariants of the buffer.
  a_count_bound: assert property (@(posedge clk) disable iff (!rst) count_q <= FULL_CNT);
  a_emit_mask:   assert property (@(posedge clk) disable iff (!rst) emit |-> (rem_q != '0));
  a_idle_empty:  assert property (@(posedge clk) disable iff (!rst) !emit |-> (count_q == '0));
  a_stall_hold:  assert property (@(posedge clk) disable iff (!rst)
                   (emit && !bus.out_ready) |=> (emit && $stable(sel) && $stable(rd_ptr_q)));
endmodule

// File: tb/tb_commit_trace_buffer.sv
module tb_commit_trace_buffer;
  logic clk;
  logic rst;

  commit_trace_buffer_if #(.LANES(4), .AREG_W(8), .PREG_W(8), .XLEN(32), .CNT_W(64)) ifc ();

  commit_trace_buffer #(
    .LANES(4), .AREG_W(8), .PREG_W(8), .XLEN(32), .DEPTH(8), .CNT_W(64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  lane;
    logic        last;
    logic        we;
    logic [7:0]  addr;
    logic [7:0]  tag;
    logic [31:0] wdata;
    logic [31:0] pc;
  } rec_t;

  typedef struct {
    logic [3:0]      mask;
    int              n;
    logic [3:0][1:0] lanes;
    logic [31:0]     base;
  } vec_t;

  rec_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic logic [31:0] f_pc(input logic [31:0] base, input logic [1:0] l);
    return base + {28'd0, l, 2'b00};
  endfunction
  function automatic logic [31:0] f_wd(input logic [31:0] base, input logic [1:0] l);
    return base ^ 32'h5A5A_0000 ^ {30'd0, l};
  endfunction
  function automatic logic [7:0] f_addr(input logic [31:0] base, input logic [1:0] l);
    return base[15:8] + {6'd0, l};
  endfunction
  function automatic logic [3:0][1:0] mk_lanes(input int a, input int b, input int c, input int d);
    logic [3:0][1:0] r;
    r[0] = 2'(a); r[1] = 2'(b); r[2] = 2'(c); r[3] = 2'(d);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one group for one edge; queue its expected records if it should be accepted.
  task automatic push_group(input logic [3:0] mask, input logic [31:0] base, input bit acc,
                            input int n, input logic [3:0][1:0] lanes);
    rec_t r;
    for (int l = 0; l < 4; l++) begin
      ifc.in_rat_we[l]         = l[0];
      ifc.in_rat_addr[l*8 +: 8] = f_addr(base, 2'(l));
      ifc.in_rat_data[l*8 +: 8] = ~f_addr(base, 2'(l));
      ifc.in_wdata[l*32 +: 32]  = f_wd(base, 2'(l));
      ifc.in_pc[l*32 +: 32]     = f_pc(base, 2'(l));
    end
    ifc.in_valid = mask;
    check("in_ready at push", {63'd0, ifc.in_ready}, {63'd0, acc});
    if (acc) begin
      for (int k = 0; k < n; k++) begin
        r.lane  = lanes[k];
        r.last  = (k == n - 1);
        r.we    = lanes[k][0];
        r.addr  = f_addr(base, lanes[k]);
        r.tag   = ~f_addr(base, lanes[k]);
        r.wdata = f_wd(base, lanes[k]);
        r.pc    = f_pc(base, lanes[k]);
        sb.push_back(r);
      end
    end
    tick();
    ifc.in_valid = '0;
  endtask

  task automatic wait_drain(input int max_cyc);
    bit done;
    done = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      if (sb.size() == 0 && ifc.empty) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    check("drain within budget", {63'd0, done}, 64'd1);
  endtask

  // Scoreboard: every handshake must match the oldest outstanding expected record.
  always @(negedge clk) begin
    rec_t e;
    if (rst && ifc.out_valid && ifc.out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected record pc", {32'd0, ifc.out_pc}, 64'hDEAD);
      end else begin
        e = sb.pop_front();
        check("rec lane", {62'd0, ifc.out_lane}, {62'd0, e.lane});
        check("rec last", {63'd0, ifc.out_last}, {63'd0, e.last});
        check("rec pc",   {32'd0, ifc.out_pc},   {32'd0, e.pc});
        check("rec payload",
              {15'd0, ifc.out_rat_we, ifc.out_rat_addr, ifc.out_rat_data, ifc.out_wdata},
              {15'd0, e.we, e.addr, e.tag, e.wdata});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[6];
    logic [63:0] ret0;
    logic [3:0][1:0] l_b2b;
    logic [1:0]  b2b_lane[4];
    logic        b2b_last[4];

    vecs[0] = '{mask: 4'b0001, n: 1, lanes: mk_lanes(0, 0, 0, 0), base: 32'h1000_0000};
    vecs[1] = '{mask: 4'b1000, n: 1, lanes: mk_lanes(3, 0, 0, 0), base: 32'h1000_0100};
    vecs[2] = '{mask: 4'b0110, n: 2, lanes: mk_lanes(1, 2, 0, 0), base: 32'h1000_0200};
    vecs[3] = '{mask: 4'b1111, n: 4, lanes: mk_lanes(0, 1, 2, 3), base: 32'h1000_0300};
    vecs[4] = '{mask: 4'b0101, n: 2, lanes: mk_lanes(0, 2, 0, 0), base: 32'h1000_0400};
    vecs[5] = '{mask: 4'b1010, n: 2, lanes: mk_lanes(1, 3, 0, 0), base: 32'h1000_0500};

    rst = 1'b0;
    ifc.in_valid = '0; ifc.in_rat_we = '0; ifc.in_rat_addr = '0; ifc.in_rat_data = '0;
    ifc.in_wdata = '0; ifc.in_pc = '0; ifc.out_ready = 1'b0;
    #1;
    check("reset in_ready",   {63'd0, ifc.in_ready},  64'd1);
    check("reset out_valid",  {63'd0, ifc.out_valid}, 64'd0);
    check("reset out_last",   {63'd0, ifc.out_last},  64'd0);
    check("reset overflow",   {63'd0, ifc.overflow},  64'd0);
    check("reset drop_cnt",   {48'd0, ifc.drop_cnt},  64'd0);
    check("reset retire_cnt", ifc.retire_cnt,         64'd0);
    check("reset empty",      {63'd0, ifc.empty},     64'd1);
    check("reset out_pc",     {32'd0, ifc.out_pc},    64'd0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // Single group 1011: lanes 0,1,3 on consecutive cycles.
    ifc.out_ready = 1'b1;
    check("t1 idle out_valid", {63'd0, ifc.out_valid}, 64'd0);
    push_group(4'b1011, 32'h8000_0000, 1'b1, 3, mk_lanes(0, 1, 3, 0));
    check("t1 latency valid", {63'd0, ifc.out_valid}, 64'd1);
    check("t1 rec0 pc",   {32'd0, ifc.out_pc},   64'h8000_0000);
    check("t1 rec0 last", {63'd0, ifc.out_last}, 64'd0);
    tick();
    check("t1 rec1 pc",   {32'd0, ifc.out_pc},   64'h8000_0004);
    check("t1 rec1 last", {63'd0, ifc.out_last}, 64'd0);
    tick();
    check("t1 rec2 pc",   {32'd0, ifc.out_pc},   64'h8000_000C);
    check("t1 rec2 last", {63'd0, ifc.out_last}, 64'd1);
    tick();
    check("t1 retire_cnt", ifc.retire_cnt, 64'd3);
    check("t1 empty",     {63'd0, ifc.empty}, 64'd1);

    // Table-driven masks.
    for (int v = 0; v < 6; v++) begin
      ret0 = ifc.retire_cnt;
      push_group(vecs[v].mask, vecs[v].base, 1'b1, vecs[v].n, vecs[v].lanes);
      wait_drain(20);
      check("vec retire delta", ifc.retire_cnt - ret0, 64'(vecs[v].n));
    end

    // Backpressure: stall 5 cycles on lane 1 of a full group.
    ret0 = ifc.retire_cnt;
    push_group(4'b1111, 32'h9000_0000, 1'b1, 4, mk_lanes(0, 1, 2, 3));
    tick();
    ifc.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check("stall valid", {63'd0, ifc.out_valid}, 64'd1);
      check("stall lane",  {62'd0, ifc.out_lane},  64'd1);
      check("stall pc",    {32'd0, ifc.out_pc},    64'h9000_0004);
      check("stall wdata", {32'd0, ifc.out_wdata}, {32'd0, f_wd(32'h9000_0000, 2'd1)});
      check("stall retire frozen", ifc.retire_cnt, ret0 + 64'd1);
      tick();
    end
    ifc.out_ready = 1'b1;
    wait_drain(20);
    check("stall retire total", ifc.retire_cnt, ret0 + 64'd4);

    // Fill to DEPTH with output blocked, two further groups dropped.
    ifc.out_ready = 1'b0;
    ret0 = ifc.retire_cnt;
    for (int i = 0; i < 10; i++)
      push_group(4'b0001, 32'hA000_0000 + 32'(i * 256), i < 8, 1, mk_lanes(0, 0, 0, 0));
    check("fill in_ready",  {63'd0, ifc.in_ready}, 64'd0);
    check("fill overflow",  {63'd0, ifc.overflow}, 64'd1);
    check("fill drop_cnt",  {48'd0, ifc.drop_cnt}, 64'd2);
    // Zero-valid groups while full are neither stored nor dropped.
    ifc.in_pc = '1;
    tick(); tick();
    check("zero-valid drop_cnt", {48'd0, ifc.drop_cnt}, 64'd2);
    // Pop while full: in_ready stays low this cycle, so this push is dropped.
    ifc.out_ready = 1'b1;
    check("fullpop same-cycle in_ready", {63'd0, ifc.in_ready}, 64'd0);
    push_group(4'b0001, 32'hB000_0000, 1'b0, 1, mk_lanes(0, 0, 0, 0));
    ifc.out_ready = 1'b0;
    check("fullpop next in_ready", {63'd0, ifc.in_ready}, 64'd1);
    check("fullpop drop_cnt",      {48'd0, ifc.drop_cnt}, 64'd3);
    ifc.out_ready = 1'b1;
    wait_drain(40);
    check("fill drained count", ifc.retire_cnt - ret0, 64'd8);

    // Zero-valid input into an empty buffer produces nothing.
    for (int c = 0; c < 3; c++) tick();
    check("zero-valid out_valid", {63'd0, ifc.out_valid}, 64'd0);
    check("zero-valid empty",     {63'd0, ifc.empty},     64'd1);

    // Back-to-back groups: lanes 0,1,2,3,2 with no bubble.
    ret0 = ifc.retire_cnt;
    l_b2b = mk_lanes(0, 1, 2, 3);
    push_group(4'b1111, 32'hC000_0000, 1'b1, 4, l_b2b);
    check("b2b rec0 lane", {62'd0, ifc.out_lane}, 64'd0);
    push_group(4'b0100, 32'hC000_1000, 1'b1, 1, mk_lanes(2, 0, 0, 0));
    b2b_lane = '{2'd1, 2'd2, 2'd3, 2'd2};
    b2b_last = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 4; k++) begin
      check("b2b valid", {63'd0, ifc.out_valid}, 64'd1);
      check("b2b lane",  {62'd0, ifc.out_lane},  {62'd0, b2b_lane[k]});
      check("b2b last",  {63'd0, ifc.out_last},  {63'd0, b2b_last[k]});
      tick();
    end
    check("b2b idle after", {63'd0, ifc.out_valid}, 64'd0);
    check("b2b retire", ifc.retire_cnt - ret0, 64'd5);

    // Asynchronous reset in the middle of a drain.
    push_group(4'b1111, 32'hD000_0000, 1'b1, 4, mk_lanes(0, 1, 2, 3));
    check("arst pre valid", {63'd0, ifc.out_valid}, 64'd1);
    #2;
    rst = 1'b0;
    #1;
    sb.delete();
    check("arst out_valid",   {63'd0, ifc.out_valid}, 64'd0);
    check("arst in_ready",    {63'd0, ifc.in_ready},  64'd1);
    check("arst overflow",    {63'd0, ifc.overflow},  64'd0);
    check("arst drop_cnt",    {48'd0, ifc.drop_cnt},  64'd0);
    check("arst retire_cnt",  ifc.retire_cnt,         64'd0);
    check("arst empty",       {63'd0, ifc.empty},     64'd1);
    check("arst out_pc",      {32'd0, ifc.out_pc},    64'd0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    tick();
    check("post-arst empty", {63'd0, ifc.empty}, 64'd1);
    push_group(4'b0100, 32'hE000_0000, 1'b1, 1, mk_lanes(2, 0, 0, 0));
    check("post-arst valid",  {63'd0, ifc.out_valid}, 64'd1);
    check("post-arst lane",   {62'd0, ifc.out_lane},  64'd2);
    check("post-arst retire0", ifc.retire_cnt, 64'd0);
    tick();
    check("post-arst retire1", ifc.retire_cnt, 64'd1);
    check("post-arst empty2",  {63'd0, ifc.empty}, 64'd1);
    check("scoreboard empty",  64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
